fifo_1kx16: RTL and testbench
=============================

FIFO_1KX16 -- requirements
Module: fifo_1kx16

Interface
REQ-001 SHALL provide parameter WIDTH, default 16: data word width in bits; only 16 is required.
REQ-002 SHALL provide parameter DEPTH, default 1024: storage depth in words; a power of two; only 1024 is required.
REQ-003 SHALL provide port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL provide port sclr, input, 1 bit: reset; synchronous, active-high.
REQ-005 SHALL provide port data, input, 16 bits: write data.
REQ-006 SHALL provide port wrreq, input, 1 bit: write request.
REQ-007 SHALL provide port rdreq, input, 1 bit: read request.
REQ-008 SHALL provide port q, output, 16 bits: registered read data.
REQ-009 SHALL provide port empty, output, 1 bit: high when the word count is 0.
REQ-010 SHALL provide port full, output, 1 bit: high when the word count is 1024.
REQ-011 SHALL provide port usedw, output, 11 bits: current word count, 0..1024; no wrap at 1024.

Function
REQ-012 SHALL behave as a first-in first-out queue: words are read in exactly the order written.
REQ-013 SHALL accept a write on a rising edge when wrreq=1 and full=0; data is stored at the write pointer, and the write pointer advances modulo 1024.
REQ-014 SHALL accept a read on a rising edge when rdreq=1 and empty=0; the word at the read pointer is loaded into q on that same edge, and the read pointer advances modulo 1024.
REQ-015 SHALL use normal (non-show-ahead) read mode: read latency is one clock, and q is valid in the cycle after the rdreq cycle.
REQ-016 SHALL hold q unchanged in every cycle without an accepted read.
REQ-017 SHALL ignore wrreq while full=1 (overflow protection): no storage change, no pointer change, no usedw change.
REQ-018 SHALL ignore rdreq while empty=1 (underflow protection): q holds its value and no pointer changes.
REQ-019 SHALL, when both wrreq and rdreq are high and 0<usedw<1024, perform both operations in the cycle, leaving usedw unchanged.
REQ-020 SHALL, when both wrreq and rdreq are high with empty=1, perform only the write: usedw becomes 1 and q is unchanged.
REQ-021 SHALL, when both wrreq and rdreq are high with full=1, perform both operations: q gets the oldest word, the new word is stored, and usedw stays 1024.
REQ-022 SHALL never allow a word written in cycle N to be read before cycle N+1; there is no write-to-read bypass.
REQ-023 SHALL update usedw as: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-024 SHALL register empty, full and usedw so that they reflect the updated count on the edge where the operation is accepted.
REQ-025 SHALL hold storage in a 1024x16 memory array; memory contents need not be cleared.

Reset
REQ-026 SHALL, when sclr=1 on a rising edge, set the read pointer, write pointer and usedw to 0, set empty=1, full=0 and q=16'h0000.
REQ-027 SHALL give sclr priority over any simultaneous wrreq or rdreq; no write or read is performed in that cycle.
REQ-028 SHALL accept a write in the first cycle after sclr deasserts.
REQ-029 SHALL provide power-up register values equal to the sclr values.
REQ-030 SHALL, after an sclr mid-operation, never return any word written before the sclr.

Verification
REQ-031 SHALL pass this scenario: write 16'hA001, 16'hA002, 16'hA003, then read 3 -> q = A001, A002, A003, each one cycle after its rdreq; usedw sequence 1,2,3,2,1,0; empty=1 at the end.
REQ-032 SHALL pass this scenario: 1024 writes of values 0..1023 -> full=1, usedw=1024; a 1025th write of 16'hFFFF is ignored; 1024 reads return 0..1023 in order, then empty=1.
REQ-033 SHALL pass this scenario: rdreq=1 while empty, after a last read returned 16'h1234 -> q stays 16'h1234, usedw stays 0, and no pointer moves.
REQ-034 SHALL pass this scenario: with usedw=5, hold wrreq=rdreq=1 for 10 cycles -> usedw stays 5 and output order is preserved across the pointer wrap at 1023->0.
REQ-035 SHALL pass this scenario: with usedw=7, assert sclr together with wrreq=1 -> next cycle usedw=0, empty=1, q=0; new writes afterwards read back correctly.
REQ-036 SHALL pass this scenario: empty FIFO with wrreq=rdreq=1 and data=16'h00FF -> usedw=1, q unchanged; a read next cycle returns 16'h00FF.

Source files
------------

// File: rtl/fifo_1kx16.sv
// Single-clock 1024x16 FIFO, normal (non-show-ahead) read mode.
// q, empty, full and usedw are all registered; sclr is synchronous and wins over requests.
module fifo_1kx16 #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 1024
) (
    input  logic                     clock,
    input  logic                     sclr,
    input  logic [WIDTH-1:0]         data,
    input  logic                     wrreq,
    input  logic                     rdreq,
    output logic [WIDTH-1:0]         q,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   usedw
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    usedw_q, usedw_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic [WIDTH-1:0] q_q, q_d;

    logic             wr_en_c;
    logic             rd_en_c;

    // A write is still accepted while full when a read frees a slot in the same edge.
    always_comb begin
        rd_en_c = !sclr && rdreq && !empty_q;
        wr_en_c = !sclr && wrreq && (!full_q || rd_en_c);
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        usedw_d  = usedw_q;
        q_d      = q_q;

        if (wr_en_c) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_en_c) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            q_d      = mem_q[rd_ptr_q];
        end

        case ({wr_en_c, rd_en_c})
            2'b10:   usedw_d = usedw_q + CW'(1);
            2'b01:   usedw_d = usedw_q - CW'(1);
            default: usedw_d = usedw_q;
        endcase

        empty_d = (usedw_d == CW'(0));
        full_d  = (usedw_d == CW'(DEPTH));
    end

    always_ff @(posedge clock) begin
        if (sclr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            usedw_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            q_q      <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            usedw_q  <= usedw_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            q_q      <= q_d;
        end
    end

    // Storage has no reset; the read above samples the old word when both hit the same slot.
    always_ff @(posedge clock) begin
        if (wr_en_c) begin
            mem_q[wr_ptr_q] <= data;
        end
    end

    assign q     = q_q;
    assign empty = empty_q;
    assign full  = full_q;
    assign usedw = usedw_q;

endmodule

// File: tb/tb_fifo_1kx16.sv
// Self-checking bench for fifo_1kx16: directed vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_fifo_1kx16;

    logic        clock;
    logic        sclr;
    logic [15:0] data;
    logic        wrreq;
    logic        rdreq;
    logic [15:0] q;
    logic        empty;
    logic        full;
    logic [10:0] usedw;

    int n_vec;
    int n_err;

    // Reference model: contents in write order and the last value loaded into q.
    logic [15:0] mq [$];
    logic [15:0] m_q;

    fifo_1kx16 dut (
        .clock (clock),
        .sclr  (sclr),
        .data  (data),
        .wrreq (wrreq),
        .rdreq (rdreq),
        .q     (q),
        .empty (empty),
        .full  (full),
        .usedw (usedw)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        s;
        logic        w;
        logic        r;
        logic [15:0] d;
        logic [15:0] eq;
        int          eu;
        logic        ee;
        logic        ef;
    } vec_t;

    localparam int NV = 20;
    vec_t tbl [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model by the same edge, settle past the edge.
    task automatic step(input logic s, input logic w, input logic r, input logic [15:0] d);
        logic rd_ok;
        logic wr_ok;
        @(negedge clock);
        sclr  = s;
        wrreq = w;
        rdreq = r;
        data  = d;
        @(posedge clock);
        if (s) begin
            mq.delete();
            m_q = 16'h0000;
        end else begin
            rd_ok = r && (mq.size() > 0);
            wr_ok = w && ((mq.size() < 1024) || rd_ok);
            if (rd_ok) m_q = mq.pop_front();
            if (wr_ok) mq.push_back(d);
        end
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".q"},     32'(q),     32'(m_q));
        check({tag, ".usedw"}, 32'(usedw), 32'(mq.size()));
        check({tag, ".empty"}, 32'(empty), 32'(mq.size() == 0));
        check({tag, ".full"},  32'(full),  32'(mq.size() == 1024));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        m_q   = 16'h0000;
        sclr  = 1'b1;
        wrreq = 1'b0;
        rdreq = 1'b0;
        data  = 16'h0000;

        //          s  w  r  data       q          usedw empty full
        tbl[0]  = '{1, 0, 0, 16'h0000, 16'h0000, 0, 1, 0};
        tbl[1]  = '{0, 1, 0, 16'hA001, 16'h0000, 1, 0, 0};
        tbl[2]  = '{0, 1, 0, 16'hA002, 16'h0000, 2, 0, 0};
        tbl[3]  = '{0, 1, 0, 16'hA003, 16'h0000, 3, 0, 0};
        tbl[4]  = '{0, 0, 1, 16'h0000, 16'hA001, 2, 0, 0};
        tbl[5]  = '{0, 0, 1, 16'h0000, 16'hA002, 1, 0, 0};
        tbl[6]  = '{0, 0, 1, 16'h0000, 16'hA003, 0, 1, 0};
        tbl[7]  = '{0, 0, 1, 16'h0000, 16'hA003, 0, 1, 0};
        tbl[8]  = '{0, 1, 1, 16'h00FF, 16'hA003, 1, 0, 0};
        tbl[9]  = '{0, 0, 1, 16'h0000, 16'h00FF, 0, 1, 0};
        tbl[10] = '{0, 1, 0, 16'h1234, 16'h00FF, 1, 0, 0};
        tbl[11] = '{0, 0, 1, 16'h0000, 16'h1234, 0, 1, 0};
        tbl[12] = '{0, 0, 1, 16'h0000, 16'h1234, 0, 1, 0};
        tbl[13] = '{0, 0, 0, 16'h0000, 16'h1234, 0, 1, 0};
        tbl[14] = '{0, 1, 0, 16'hC001, 16'h1234, 1, 0, 0};
        tbl[15] = '{0, 1, 0, 16'hC002, 16'h1234, 2, 0, 0};
        tbl[16] = '{0, 1, 0, 16'hC003, 16'h1234, 3, 0, 0};
        tbl[17] = '{1, 1, 1, 16'hDEAD, 16'h0000, 0, 1, 0};
        tbl[18] = '{0, 1, 0, 16'hBEEF, 16'h0000, 1, 0, 0};
        tbl[19] = '{0, 0, 1, 16'h0000, 16'hBEEF, 0, 1, 0};

        for (int i = 0; i < NV; i++) begin
            step(tbl[i].s, tbl[i].w, tbl[i].r, tbl[i].d);
            check($sformatf("vec%0d.q", i),     32'(q),     32'(tbl[i].eq));
            check($sformatf("vec%0d.usedw", i), 32'(usedw), 32'(tbl[i].eu));
            check($sformatf("vec%0d.empty", i), 32'(empty), 32'(tbl[i].ee));
            check($sformatf("vec%0d.full", i),  32'(full),  32'(tbl[i].ef));
        end

        // sclr with 7 words held and a concurrent write, then fresh traffic.
        step(1, 0, 0, 16'h0000);
        for (int i = 0; i < 7; i++) step(0, 1, 0, 16'h7000 + 16'(i));
        check("pre_sclr.usedw", 32'(usedw), 32'd7);
        step(1, 1, 0, 16'h7777);
        check("sclr.usedw", 32'(usedw), 32'd0);
        check("sclr.empty", 32'(empty), 32'd1);
        check("sclr.q",     32'(q),     32'd0);
        step(0, 1, 0, 16'h4242);
        step(0, 1, 0, 16'h4343);
        step(0, 0, 1, 16'h0000);
        check("post_sclr.rd0", 32'(q), 32'h4242);
        step(0, 0, 1, 16'h0000);
        check("post_sclr.rd1", 32'(q), 32'h4343);
        check("post_sclr.empty", 32'(empty), 32'd1);

        // Fill to 1024, overflow write ignored, drain in order.
        step(1, 0, 0, 16'h0000);
        for (int i = 0; i < 1024; i++) step(0, 1, 0, 16'(i));
        check("fill.full",  32'(full),  32'd1);
        check("fill.usedw", 32'(usedw), 32'd1024);
        step(0, 1, 0, 16'hFFFF);
        check("ovf.usedw", 32'(usedw), 32'd1024);
        check("ovf.full",  32'(full),  32'd1);
        check("ovf.q",     32'(q),     32'd0);
        for (int i = 0; i < 1024; i++) begin
            step(0, 0, 1, 16'h0000);
            check($sformatf("drain%0d", i), 32'(q), 32'(i));
        end
        check("drain.empty", 32'(empty), 32'd1);
        check("drain.usedw", 32'(usedw), 32'd0);

        // Simultaneous read and write while full.
        for (int i = 0; i < 1024; i++) step(0, 1, 0, 16'(i) ^ 16'h5A5A);
        step(0, 1, 1, 16'h7777);
        check("full_both.q",     32'(q),     32'h5A5A);
        check("full_both.usedw", 32'(usedw), 32'd1024);
        check("full_both.full",  32'(full),  32'd1);
        for (int i = 0; i < 1024; i++) step(0, 0, 1, 16'h0000);
        check_model("full_both_drain");
        check("full_both.last", 32'(q), 32'h7777);

        // Move both pointers to 1019, then run 10 read+write cycles across the wrap.
        step(1, 0, 0, 16'h0000);
        step(0, 1, 0, 16'h0000);
        for (int i = 0; i < 1018; i++) step(0, 1, 1, 16'(i + 1));
        step(0, 0, 1, 16'h0000);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 16'hE000 + 16'(i));
        check("wrap.usedw0", 32'(usedw), 32'd5);
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 1, 16'hF000 + 16'(i));
            check($sformatf("wrap.usedw%0d", i + 1), 32'(usedw), 32'd5);
            check($sformatf("wrap.q%0d", i), 32'(q),
                  (i < 5) ? 32'(16'hE000 + 16'(i)) : 32'(16'hF000 + 16'(i - 5)));
        end
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 16'h0000);
            check($sformatf("wrap.drain%0d", i), 32'(q), 32'(16'hF005 + 16'(i)));
        end
        check("wrap.empty", 32'(empty), 32'd1);

        // Randomized traffic: fill-biased, then drain-biased, rare sclr.
        step(1, 0, 0, 16'h0000);
        for (int ph = 0; ph < 3; ph++) begin
            for (int i = 0; i < 2500; i++) begin
                int unsigned wp;
                int unsigned rp;
                wp = (ph == 1) ? 35 : 75;
                rp = (ph == 1) ? 75 : 40;
                step(($urandom_range(999) == 0) ? 1'b1 : 1'b0,
                     ($urandom_range(99) < wp) ? 1'b1 : 1'b0,
                     ($urandom_range(99) < rp) ? 1'b1 : 1'b0,
                     16'($urandom));
                check_model($sformatf("rnd%0d_%0d", ph, i));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
